decode_serialize_ctrl: RTL and testbench
========================================

// Module: decode_serialize_ctrl
// PURPOSE
//  Sequences decoded bundles from the decode lanes into the instruction buffer.
//  Serializing instructions (isCSR/isSret/isMret/isScall/isSbreak/exception) are
//  held until the backend drains, then written alone. Younger lanes resume only
//  after that instruction commits. Sits between decode and the instruction buffer.
// PARAMETERS
//  DISPATCH_WIDTH  4     decode lanes per bundle; lane 0 is oldest
//  WAIT_TIMEOUT    4096  WAIT_COMMIT cycles before hang_o asserts
// PORTS
//  clk             in   1   core clock
//  reset           in   1   synchronous, active-high
//  flush_i         in   1   recovery/exception flush of the front end
//  decValid_i      in   W   per-lane renPkt.valid (W = DISPATCH_WIDTH)
//  decSerial_i     in   W   per-lane OR of isCSR,isSret,isMret,isScall,isSbreak,exception
//  ibReady_i       in   1   instruction buffer accepts a write this cycle
//  ibEmpty_i       in   1   instruction buffer holds no instructions
//  alEmpty_i       in   1   active list empty
//  serialCommit_i  in   1   the outstanding serializing instruction committed
//  ibWriteMask_o   out  W   lanes written into the instruction buffer this cycle
//  decStall_o      out  1   decode must hold the current bundle next cycle
//  state_o         out  2   current FSM state (debug)
//  hang_o          out  1   sticky watchdog flag
// BEHAVIOUR
//  - Reset: state=NORMAL, basePtr=0, waitCnt=0, hang_o=0.
//    ibWriteMask_o=0 and decStall_o=0 during the reset cycle.
//  - Outputs are combinational from registered state and current inputs.
//    Updates take effect at the next clk edge.
//  - basePtr is $clog2(W)+1 bits wide: the first unconsumed lane of the held bundle.
//  - Serial lane s = lowest lane >= basePtr with decValid_i & decSerial_i.
//    Lanes with decValid_i=0 are never written and never count as serial.
//  - NORMAL:
//    - ibReady_i=0 -> mask=0, stall=1 if any valid lane >= basePtr.
//    - No s -> mask = valid lanes >= basePtr, stall=0, basePtr<=0.
//    - s>basePtr -> mask = valid lanes in [basePtr,s), stall=1, basePtr<=s.
//    - s==basePtr -> mask=0, stall=1, go DRAIN.
//  - DRAIN: mask=0, stall=1. Go ISSUE when alEmpty_i & ibEmpty_i; otherwise stay.
//  - ISSUE: stall=1. When ibReady_i: mask = onehot(basePtr), basePtr<=basePtr+1,
//    waitCnt<=0, go WAIT_COMMIT. Otherwise mask=0 and stay.
//  - WAIT_COMMIT: mask=0, waitCnt++ (saturating).
//    - serialCommit_i -> go NORMAL. If basePtr==W: stall=0 this cycle, basePtr<=0.
//      Otherwise stall=1.
//    - No commit -> stall=1.
//    - waitCnt==WAIT_TIMEOUT-1 -> hang_o<=1 (sticky until reset).
//  - A serialCommit_i outside WAIT_COMMIT is ignored.
//  - flush_i (highest priority after reset, any state): mask=0, stall=0,
//    next state NORMAL, basePtr<=0, waitCnt<=0. hang_o is unchanged.
//  - A bundle whose only valid lanes are below basePtr releases with stall=0, mask=0.
//  - Back-to-back serial lanes: each gets its own DRAIN/ISSUE/WAIT_COMMIT pass.
//  - Invariant: at most one lane is set in ibWriteMask_o outside NORMAL.
// STRUCTURE
//  - Shared decode package: typedef enum logic[1:0] {NORMAL,DRAIN,ISSUE,WAIT_COMMIT}
//    serCtrlState_t, and the `DISPATCH_WIDTH constant.
//  - Sub-module serial_lane_find: combinational priority finder.
//    Inputs: valid, serial, basePtr. Outputs: found, s, a mask of valid lanes
//    in [basePtr,s).
//  - Top: FSM, basePtr register, waitCnt register, output muxing.
// TESTING
//  1. W=4, valid=1111, serial=0000, ibReady=1 -> mask=1111, stall=0 in 1 cycle.
//  2. valid=1111, serial=0100, alEmpty/ibEmpty raised 3 cycles after lanes 0-1 are
//     written -> mask=0011, then 0000 x3, then 0100 in ISSUE. On serialCommit_i,
//     stall=1; the next cycle mask=1000, stall=0.
//  3. valid=1111, serial=1001 -> 0001 alone; after commit, 0110; then 1000 alone;
//     after commit, stall=0. Two full serialize passes.
//  4. ISSUE with ibReady=0 for 5 cycles -> mask=0 and the state holds ISSUE.
//     ibReady=1 -> onehot written once.
//  5. flush_i in DRAIN and in WAIT_COMMIT -> next cycle state=NORMAL, basePtr=0,
//     mask=0 and stall=0 in the flush cycle. A later serialCommit_i is ignored.
//  6. WAIT_TIMEOUT=16, no commit -> hang_o=1 at cycle 16 of WAIT_COMMIT and stays
//     set across a flush. reset clears it.

Source files
------------

// File: rtl/decode_serialize_ctrl_pkg.sv
// Shared decode-side definitions for the serializing dispatch controller:
// default lane count and the controller's state encoding.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package decode_serialize_ctrl_pkg;

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    DRAIN       = 2'd1,
    ISSUE       = 2'd2,
    WAIT_COMMIT = 2'd3
  } serCtrlState_t;

endpackage

// File: rtl/decode_serialize_ctrl_if.sv
// Decode-lane / instruction-buffer handshake bundle seen by the serializing controller.
interface decode_serialize_ctrl_if #(
  parameter int W = `DISPATCH_WIDTH
) ();

  logic [W-1:0] decValid_i;
  logic [W-1:0] decSerial_i;
  logic         ibReady_i;
  logic         ibEmpty_i;
  logic         alEmpty_i;
  logic         serialCommit_i;
  logic [W-1:0] ibWriteMask_o;
  logic         decStall_o;

  modport master (
    output decValid_i, decSerial_i, ibReady_i, ibEmpty_i, alEmpty_i, serialCommit_i,
    input  ibWriteMask_o, decStall_o
  );

  modport slave (
    input  decValid_i, decSerial_i, ibReady_i, ibEmpty_i, alEmpty_i, serialCommit_i,
    output ibWriteMask_o, decStall_o
  );

endinterface

// File: rtl/decode_serialize_ctrl_serial_lane_find.sv
// Finds the oldest valid serializing lane at or above base_ptr_i and the
// valid lanes that precede it; with no such lane, s_o reads as W.
module serial_lane_find #(
  parameter int W     = 4,
  parameter int PTR_W = $clog2(W) + 1
) (
  input  logic [W-1:0]     valid_i,
  input  logic [W-1:0]     serial_i,
  input  logic [PTR_W-1:0] base_ptr_i,
  output logic             found_o,
  output logic [PTR_W-1:0] s_o,
  output logic [W-1:0]     pre_mask_o,
  output logic             pend_o
);

  always_comb begin
    found_o    = 1'b0;
    s_o        = PTR_W'(W);
    pre_mask_o = '0;
    pend_o     = 1'b0;
    // Walk from youngest to oldest so the last hit is the oldest serial lane.
    for (int l = W - 1; l >= 0; l--) begin
      if (valid_i[l] && (PTR_W'(l) >= base_ptr_i)) begin
        pend_o = 1'b1;
        if (serial_i[l]) begin
          found_o = 1'b1;
          s_o     = PTR_W'(l);
        end
      end
    end
    for (int l = 0; l < W; l++) begin
      pre_mask_o[l] = valid_i[l] && (PTR_W'(l) >= base_ptr_i) && (PTR_W'(l) < s_o);
    end
  end

endmodule

// File: rtl/decode_serialize_ctrl.sv
// Sequences decoded bundles into the instruction buffer, issuing each
// serializing instruction alone on an empty backend and waiting for its commit.
module decode_serialize_ctrl
  import decode_serialize_ctrl_pkg::*;
#(
  parameter int DISPATCH_WIDTH = `DISPATCH_WIDTH,
  parameter int WAIT_TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  decode_serialize_ctrl_if.slave       dec_bus,
  output logic [1:0]                   state_o,
  output logic                         hang_o
);

  localparam int W     = DISPATCH_WIDTH;
  localparam int PTR_W = $clog2(W) + 1;
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(W);

  serCtrlState_t    state_q, state_d;
  logic [PTR_W-1:0] base_ptr_q, base_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             hang_q, hang_d;

  logic             found;
  logic [PTR_W-1:0] serial_lane;
  logic [W-1:0]     pre_mask;
  logic             pend;
  logic [W-1:0]     write_mask;
  logic             stall;

  serial_lane_find #(.W(W), .PTR_W(PTR_W)) u_find (
    .valid_i    (dec_bus.decValid_i),
    .serial_i   (dec_bus.decSerial_i),
    .base_ptr_i (base_ptr_q),
    .found_o    (found),
    .s_o        (serial_lane),
    .pre_mask_o (pre_mask),
    .pend_o     (pend)
  );

  always_comb begin
    state_d    = state_q;
    base_ptr_d = base_ptr_q;
    wait_cnt_d = wait_cnt_q;
    hang_d     = hang_q;
    write_mask = '0;
    stall      = 1'b0;

    unique case (state_q)
      NORMAL: begin
        if (!dec_bus.ibReady_i) begin
          stall = pend;
        end else if (!found) begin
          write_mask = pre_mask;
          base_ptr_d = '0;
        end else if (serial_lane > base_ptr_q) begin
          write_mask = pre_mask;
          stall      = 1'b1;
          base_ptr_d = serial_lane;
        end else begin
          stall   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (dec_bus.alEmpty_i && dec_bus.ibEmpty_i) state_d = ISSUE;
      end
      ISSUE: begin
        stall = 1'b1;
        if (dec_bus.ibReady_i) begin
          write_mask = W'(1) << base_ptr_q;
          base_ptr_d = base_ptr_q + PTR_W'(1);
          wait_cnt_d = '0;
          state_d    = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        stall      = 1'b1;
        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        if (wait_cnt_q == CNT_LAST) hang_d = 1'b1;
        if (dec_bus.serialCommit_i) begin
          state_d = NORMAL;
          // Serial lane was the last of the bundle: let decode move on right away.
          if (base_ptr_q == PTR_END) begin
            stall      = 1'b0;
            base_ptr_d = '0;
          end
        end
      end
      default: state_d = NORMAL;
    endcase

    if (flush_i) begin
      write_mask = '0;
      stall      = 1'b0;
      state_d    = NORMAL;
      base_ptr_d = '0;
      wait_cnt_d = '0;
      hang_d     = hang_q;
    end

    if (reset) begin
      write_mask = '0;
      stall      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      base_ptr_q <= '0;
      wait_cnt_q <= '0;
      hang_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_ptr_q <= base_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      hang_q     <= hang_d;
    end
  end

  assign dec_bus.ibWriteMask_o = write_mask;
  assign dec_bus.decStall_o    = stall;
  assign state_o               = state_q;
  assign hang_o                = hang_q;

endmodule

// File: tb/tb_decode_serialize_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a lane-by-lane behavioural model of the serializing controller.
module tb_decode_serialize_ctrl;
  import decode_serialize_ctrl_pkg::*;

  localparam int W   = `DISPATCH_WIDTH;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic [1:0] state_o;
  logic       hang_o;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  decode_serialize_ctrl_if #(.W(W)) bus ();

  decode_serialize_ctrl #(.DISPATCH_WIDTH(W), .WAIT_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .dec_bus (bus.slave),
    .state_o (state_o),
    .hang_o  (hang_o)
  );

  always #5 clk = ~clk;

  // Model: phase 0..3 = normal/drain/issue/wait, base = first unconsumed lane,
  // waited = WAIT_COMMIT cycles already spent on the current instruction.
  int           m_phase, m_base, m_waited;
  bit           m_hang;
  int           n_phase, n_base, n_waited;
  bit           n_hang;
  logic [W-1:0] e_mask;
  logic         e_stall;

  logic [W-1:0] obs_mask;
  logic         obs_stall;
  logic [1:0]   obs_state;
  logic         obs_hang;
  logic [W-1:0] cur_v, cur_s;

  int t3m [9] = '{0, 0, 1, 0, 6, 0, 0, 8, 0};
  int t3s [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] v, input logic [W-1:0] s, input logic rdy,
                               input logic ibE, input logic alE, input logic cmt, input logic fl);
    cur_v              = v;
    cur_s              = s;
    bus.decValid_i     = v;
    bus.decSerial_i    = s;
    bus.ibReady_i      = rdy;
    bus.ibEmpty_i      = ibE;
    bus.alEmpty_i      = alE;
    bus.serialCommit_i = cmt;
    flush_i            = fl;
  endtask

  task automatic modelEval();
    int  s;
    int  hi;
    bit  pending;
    n_phase  = m_phase;
    n_base   = m_base;
    n_waited = m_waited;
    n_hang   = m_hang;
    e_mask   = '0;
    e_stall  = 1'b0;
    if (reset) begin
      n_phase = 0; n_base = 0; n_waited = 0; n_hang = 0;
      return;
    end
    if (flush_i) begin
      n_phase = 0; n_base = 0; n_waited = 0;
      return;
    end
    s = -1;
    pending = 0;
    for (int l = W - 1; l >= m_base; l--) begin
      if (cur_v[l]) begin
        pending = 1;
        if (cur_s[l]) s = l;
      end
    end
    case (m_phase)
      0: begin
        if (!bus.ibReady_i) e_stall = pending;
        else begin
          hi = (s < 0) ? W : s;
          for (int l = m_base; l < hi; l++) e_mask[l] = cur_v[l];
          if (s < 0) n_base = 0;
          else if (s > m_base) begin e_stall = 1; n_base = s; end
          else begin e_stall = 1; n_phase = 1; end
        end
      end
      1: begin
        e_stall = 1;
        if (bus.alEmpty_i && bus.ibEmpty_i) n_phase = 2;
      end
      2: begin
        e_stall = 1;
        if (bus.ibReady_i) begin
          e_mask[m_base] = 1'b1;
          n_base = m_base + 1;
          n_waited = 0;
          n_phase = 3;
        end
      end
      default: begin
        n_waited = m_waited + 1;
        if (m_waited + 1 >= TMO) n_hang = 1;
        e_stall = 1;
        if (bus.serialCommit_i) begin
          n_phase = 0;
          if (m_base == W) begin e_stall = 0; n_base = 0; end
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    modelEval();
    obs_mask  = bus.ibWriteMask_o;
    obs_stall = bus.decStall_o;
    obs_state = state_o;
    obs_hang  = hang_o;
    checkOutput("ibWriteMask", 32'(obs_mask), 32'(e_mask));
    checkOutput("decStall", 32'(obs_stall), 32'(e_stall));
    checkOutput("state", 32'(obs_state), 32'(m_phase));
    checkOutput("hang", 32'(obs_hang), 32'(m_hang));
    @(posedge clk);
    m_phase  = n_phase;
    m_base   = n_base;
    m_waited = n_waited;
    m_hang   = n_hang;
    cycle++;
    #1;
  endtask

  task automatic expectOut(input string tag, input logic [W-1:0] m, input logic st);
    checkOutput({tag, "_mask"}, 32'(obs_mask), 32'(m));
    checkOutput({tag, "_stall"}, 32'(obs_stall), 32'(st));
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 1, 1, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    m_phase = 0; m_base = 0; m_waited = 0; m_hang = 0;
    step();
    expectOut("reset", 4'b0000, 1'b0);
    reset = 1'b0;

    // Plain bundle passes in one cycle.
    applyStimulus(4'b1111, 4'b0000, 1, 0, 0, 0, 0);
    step(); expectOut("t1", 4'b1111, 1'b0);

    // Serial lane 2, backend drains three cycles after the prefix is written.
    applyStimulus(4'b1111, 4'b0100, 1, 0, 0, 0, 0);
    step(); expectOut("t2_pre", 4'b0011, 1'b1);
    step(); expectOut("t2_w0", 4'b0000, 1'b1);
    step(); expectOut("t2_w1", 4'b0000, 1'b1);
    applyStimulus(4'b1111, 4'b0100, 1, 1, 1, 0, 0);
    step(); expectOut("t2_w2", 4'b0000, 1'b1);
    step(); expectOut("t2_issue", 4'b0100, 1'b1);
    applyStimulus(4'b1111, 4'b0100, 1, 1, 1, 1, 0);
    step(); expectOut("t2_commit", 4'b0000, 1'b1);
    applyStimulus(4'b1111, 4'b0100, 1, 1, 1, 0, 0);
    step(); expectOut("t2_tail", 4'b1000, 1'b0);

    // Two serial lanes; commit held high so it must be ignored outside WAIT_COMMIT.
    applyStimulus(4'b1111, 4'b1001, 1, 1, 1, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      expectOut($sformatf("t3_c%0d", i), W'(t3m[i]), t3s[i][0]);
    end

    // ISSUE holds while the buffer is not ready.
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 0);
    step(); expectOut("t4_n", 4'b0000, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 0, 1, 1, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      expectOut("t4_hold", 4'b0000, 1'b1);
      checkOutput("t4_state", 32'(obs_state), 32'(ISSUE));
    end
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 0);
    step(); expectOut("t4_issue", 4'b0001, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 1, 0);
    step(); expectOut("t4_commit", 4'b0000, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 0);
    step(); expectOut("t4_release", 4'b0000, 1'b0);

    // Flush in DRAIN, then in WAIT_COMMIT.
    applyStimulus(4'b0001, 4'b0001, 1, 0, 0, 0, 0);
    step(); step();
    applyStimulus(4'b0001, 4'b0001, 1, 0, 0, 0, 1);
    step(); expectOut("t5_flush_drain", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 1, 0, 0, 1, 0);
    step(); expectOut("t5_after_drain", 4'b1111, 1'b0);
    checkOutput("t5_state_d", 32'(obs_state), 32'(NORMAL));
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 0);
    step(); step(); step(); step();
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 1);
    step(); expectOut("t5_flush_wait", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 1, 1, 1, 1, 0);
    step(); expectOut("t5_after_wait", 4'b1111, 1'b0);
    checkOutput("t5_state_w", 32'(obs_state), 32'(NORMAL));

    // Watchdog: flag appears after the 16th WAIT_COMMIT cycle, survives flush.
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 0);
    step(); step(); step();
    for (int i = 0; i < TMO; i++) begin
      step();
      checkOutput("t6_hang_pre", 32'(obs_hang), 32'd0);
    end
    step(); checkOutput("t6_hang_set", 32'(obs_hang), 32'd1);
    applyStimulus(4'b0001, 4'b0001, 1, 1, 1, 0, 1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1, 1, 1, 0, 0);
    step(); checkOutput("t6_hang_flush", 32'(obs_hang), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); checkOutput("t6_hang_reset", 32'(obs_hang), 32'd0);

    // Randomized traffic; decode holds its bundle whenever the model says stall.
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] v;
      logic [W-1:0] s;
      v = e_stall ? cur_v : W'($urandom);
      s = e_stall ? cur_s : W'($urandom & $urandom);
      applyStimulus(v, s, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
